// File: rtl/arb_pkg.sv
// Shared types and constants for the CPU/host memory port arbiter.
package arb_pkg;

  typedef enum logic [1:0] {RUN, HOST, COOL} arbstate_t;

  localparam int CW = 8;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Host loader/debug side of the shared memory port.
// Handshake: the host holds host_req; an access is accepted in any cycle where
// host_gnt=1 and host_valid=1. Reads return one cycle later on host_rvalid.
interface mem_port_arbiter_if #(parameter int AW = 32);
  logic          host_req;
  logic          host_gnt;
  logic          host_valid;
  logic          host_we;
  logic [AW-1:0] host_adr;
  logic [AW-1:0] host_wd;
  logic [AW-1:0] host_rdata;
  logic          host_rvalid;

  modport slave (
    input  host_req, host_valid, host_we, host_adr, host_wd,
    output host_gnt, host_rdata, host_rvalid
  );

  modport master (
    output host_req, host_valid, host_we, host_adr, host_wd,
    input  host_gnt, host_rdata, host_rvalid
  );
endinterface

// File: rtl/arb_fsm.sv
// Arbiter control: RUN/HOST/COOL state, burst and cool-down counters,
// CPU clock enable and host grant.
module arb_fsm
  import arb_pkg::*;
#(
  parameter int MAX_BURST   = 16,
  parameter int COOL_CYCLES = 8
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      host_req,
  input  logic      host_valid,
  input  logic      cpu_at_fetch,
  output arbstate_t state,
  output logic      cpu_en,
  output logic      host_gnt,
  output logic      halt_now
);

  localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);
  localparam logic [CW-1:0] COOL_LOAD  = CW'(COOL_CYCLES - 1);

  arbstate_t     state_next;
  logic [CW-1:0] burst_cnt, burst_next;
  logic [CW-1:0] cool_cnt, cool_next;

  always_ff @(posedge clk, posedge reset) begin
    if (reset) begin
      state     <= RUN;
      burst_cnt <= '0;
      cool_cnt  <= '0;
    end else begin
      state     <= state_next;
      burst_cnt <= burst_next;
      cool_cnt  <= cool_next;
    end
  end

  always_comb begin
    state_next = state;
    burst_next = burst_cnt;
    cool_next  = cool_cnt;
    halt_now   = 1'b0;
    cpu_en     = 1'b1;
    host_gnt   = 1'b0;
    case (state)
      RUN: begin
        // Only stop the core at an instruction boundary; the suppressed edge
        // makes FETCH repeat once the core is released.
        if (host_req && cpu_at_fetch) begin
          halt_now   = 1'b1;
          cpu_en     = 1'b0;
          state_next = HOST;
          burst_next = '0;
        end
      end
      HOST: begin
        host_gnt = 1'b1;
        cpu_en   = 1'b0;
        if (host_valid && burst_cnt != BURST_LAST)
          burst_next = burst_cnt + 1'b1;
        if (!host_req || (host_valid && burst_cnt == BURST_LAST)) begin
          state_next = COOL;
          cool_next  = COOL_LOAD;
        end
      end
      COOL: begin
        if (cool_cnt == '0) state_next = RUN;
        else                cool_next  = cool_cnt - 1'b1;
      end
      default: state_next = RUN;
    endcase
  end

endmodule

// File: rtl/flopenr.sv
// Enabled flop with asynchronous active-high reset.
module flopenr #(parameter int WIDTH = 8) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk, posedge reset)
    if (reset)   q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/mux2.sv
// Two-input multiplexer.
module mux2 #(parameter int WIDTH = 8) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic             s,
  output logic [WIDTH-1:0] y
);
  assign y = s ? d1 : d0;
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the core's unified memory port with a host loader/debug port by
// freezing the core at FETCH and muxing the port to the host for a burst.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_BURST   = 16,
  parameter int COOL_CYCLES = 8,
  parameter int AW          = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [AW-1:0]       cpu_adr,
  input  logic [AW-1:0]       cpu_wd,
  input  logic                cpu_we,
  output logic [AW-1:0]       cpu_rd,
  input  logic                cpu_at_fetch,
  output logic                cpu_en,
  mem_port_arbiter_if.slave   host,
  output logic [AW-1:0]       mem_adr,
  output logic [AW-1:0]       mem_wd,
  output logic                mem_we,
  input  logic [AW-1:0]       mem_rd,
  output arbstate_t           dbg_state
);

  logic gnt;
  logic halt_now;
  logic rd_fire;

  arb_fsm #(.MAX_BURST(MAX_BURST), .COOL_CYCLES(COOL_CYCLES)) u_fsm (
    .clk          (clk),
    .reset        (reset),
    .host_req     (host.host_req),
    .host_valid   (host.host_valid),
    .cpu_at_fetch (cpu_at_fetch),
    .state        (dbg_state),
    .cpu_en       (cpu_en),
    .host_gnt     (gnt),
    .halt_now     (halt_now)
  );

  assign host.host_gnt = gnt;

  mux2 #(.WIDTH(AW)) u_adr_mux (.d0(cpu_adr), .d1(host.host_adr), .s(gnt), .y(mem_adr));
  mux2 #(.WIDTH(AW)) u_wd_mux  (.d0(cpu_wd),  .d1(host.host_wd),  .s(gnt), .y(mem_wd));

  // The halt cycle leaves the port idle so the frozen FETCH has no side effect.
  always_comb begin
    mem_we = cpu_we & ~halt_now;
    if (gnt) mem_we = host.host_valid & host.host_we;
  end

  assign cpu_rd  = mem_rd;
  assign rd_fire = gnt & host.host_valid & ~host.host_we;

  flopenr #(.WIDTH(AW)) u_rdata (
    .clk   (clk),
    .reset (reset),
    .en    (rd_fire),
    .d     (mem_rd),
    .q     (host.host_rdata)
  );

  always_ff @(posedge clk, posedge reset)
    if (reset) host.host_rvalid <= 1'b0;
    else       host.host_rvalid <= rd_fire;

endmodule
